// File: rtl/branch_resolve_queue_if.sv
// -----------------------------------------------------------------------------
// branch_resolve_queue_if
//
// Bundles the signals between the execute stage, the branch resolve queue and
// the global branch predictor's update port.
//
//   slave  modport : the queue's view. Resolve_* and Update_ready_IN come in;
//                    ready/valid, head entry, mispredict pulse, occupancy and
//                    statistics go out.
//   master modport : the surrounding logic's view (EXE + predictor), with
//                    every direction reversed.
//
// Parameters must match those of the branch_resolve_queue that uses the
// interface.
// -----------------------------------------------------------------------------
interface branch_resolve_queue_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  // EXE -> queue
  logic              Resolve_valid_IN;
  logic [31:0]       Resolve_addr_IN;
  logic              Resolve_taken_IN;
  logic              Resolve_pred_IN;
  logic              Resolve_ready_OUT;

  // queue -> predictor
  logic              Update_valid_OUT;
  logic [31:0]       Update_addr_OUT;
  logic              Update_taken_OUT;
  logic              Update_ready_IN;

  // status / statistics
  logic              Mispredict_OUT;
  logic [OCC_W-1:0]  Count_OUT;
  logic [CNT_W-1:0]  Branch_count_OUT;
  logic [CNT_W-1:0]  Mispredict_count_OUT;

  modport slave (
    input  Resolve_valid_IN, Resolve_addr_IN, Resolve_taken_IN, Resolve_pred_IN,
    input  Update_ready_IN,
    output Resolve_ready_OUT,
    output Update_valid_OUT, Update_addr_OUT, Update_taken_OUT,
    output Mispredict_OUT, Count_OUT, Branch_count_OUT, Mispredict_count_OUT
  );

  modport master (
    output Resolve_valid_IN, Resolve_addr_IN, Resolve_taken_IN, Resolve_pred_IN,
    output Update_ready_IN,
    input  Resolve_ready_OUT,
    input  Update_valid_OUT, Update_addr_OUT, Update_taken_OUT,
    input  Mispredict_OUT, Count_OUT, Branch_count_OUT, Mispredict_count_OUT
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// -----------------------------------------------------------------------------
// branch_resolve_queue
//
// Circular FIFO of resolved conditional branches {addr, taken} between EXE
// branch resolution and the global predictor's update port. Absorbs bursts of
// resolutions, hands the predictor one entry per cycle, pulses a registered
// mispredict flag and keeps saturating branch / mispredict counters.
//
// Ports:
//   CLK   : clock, all state changes on posedge
//   RESET : asynchronous, active-high; clears pointers, occupancy, counters
//           and the mispredict pulse (storage contents are left as they are)
//   bus   : branch_resolve_queue_if.slave
//     Resolve_valid/addr/taken/pred_IN, Resolve_ready_OUT : EXE side
//     Update_valid/addr/taken_OUT, Update_ready_IN        : predictor side
//     Mispredict_OUT                                      : 1-cycle pulse
//     Count_OUT                                           : occupancy
//     Branch_count_OUT, Mispredict_count_OUT              : saturating stats
//
// Every output is driven from registered state only, so there is no
// combinational path from an input to an output. Address 0 means "no update"
// to the predictor, so such a resolution is handshaken but dropped.
// -----------------------------------------------------------------------------
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  branch_resolve_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] addr;
    logic        taken;
  } entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q,      wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q,      rd_ptr_d;
  logic [OCC_W-1:0]  count_q,       count_d;
  logic [CNT_W-1:0]  branch_cnt_q,  branch_cnt_d;
  logic [CNT_W-1:0]  mispred_cnt_q, mispred_cnt_d;
  logic              mispred_q,     mispred_d;

  logic   full;
  logic   empty;
  logic   enq_fire;
  logic   deq_fire;
  logic   is_mispred;
  entry_t head;

  // Ready/valid come from the registered occupancy only: a dequeue while full
  // does not reopen ready until the following cycle.
  assign full     = (count_q == OCC_W'(DEPTH));
  assign empty    = (count_q == '0);

  // A zero address completes the handshake but is neither stored nor counted.
  assign enq_fire   = bus.Resolve_valid_IN && !full && (bus.Resolve_addr_IN != 32'h0);
  assign deq_fire   = !empty && bus.Update_ready_IN;
  assign is_mispred = (bus.Resolve_taken_IN != bus.Resolve_pred_IN);

  assign head = mem_q[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default before any branch so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    mispred_d     = 1'b0;

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    if (enq_fire) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (deq_fire) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    unique case ({enq_fire, deq_fire})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase

    if (enq_fire) begin
      mispred_d = is_mispred;
      if (branch_cnt_q != '1) begin
        branch_cnt_d = branch_cnt_q + CNT_W'(1);
      end
      if (is_mispred && (mispred_cnt_q != '1)) begin
        mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with non-blocking (<=) so all flops
  // sample their _d values from the same pre-edge snapshot.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
      mispred_q     <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
      mispred_q     <= mispred_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the entry array is deliberately not reset; occupancy gates every
  // read, so stale contents are never observable and the array can map to
  // plain RAM/flops without a reset network.
  always_ff @(posedge CLK) begin
    if (enq_fire) begin
      mem_q[wr_ptr_q] <= '{addr: bus.Resolve_addr_IN, taken: bus.Resolve_taken_IN};
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.Resolve_ready_OUT    = !full;
  assign bus.Update_valid_OUT     = !empty;
  assign bus.Update_addr_OUT      = empty ? 32'h0 : head.addr;
  assign bus.Update_taken_OUT     = empty ? 1'b0  : head.taken;
  assign bus.Mispredict_OUT       = mispred_q;
  assign bus.Count_OUT            = count_q;
  assign bus.Branch_count_OUT     = branch_cnt_q;
  assign bus.Mispredict_count_OUT = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_queue
//
// Directed bench for branch_resolve_queue. Main instance uses DEPTH=4,
// CNT_W=16; a second instance with DEPTH=2, CNT_W=3 reaches counter
// saturation in a handful of cycles. Inputs change 1 ns after the rising
// edge and outputs are sampled there as well, away from the edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_branch_resolve_queue;
  logic clk;
  logic rst;

  int total;
  int bad;

  branch_resolve_queue_if #(.DEPTH(4), .CNT_W(16)) bus ();
  branch_resolve_queue_if #(.DEPTH(2), .CNT_W(3))  sbus ();

  branch_resolve_queue #(.DEPTH(4), .CNT_W(16)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  branch_resolve_queue #(.DEPTH(2), .CNT_W(3)) dut_sat (
    .CLK   (clk),
    .RESET (rst),
    .bus   (sbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [31:0] addr, input logic taken, input logic pred);
    bus.Resolve_valid_IN = 1'b1;
    bus.Resolve_addr_IN  = addr;
    bus.Resolve_taken_IN = taken;
    bus.Resolve_pred_IN  = pred;
    tick();
    bus.Resolve_valid_IN = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    bus.Resolve_valid_IN  = 1'b0;
    bus.Resolve_addr_IN   = 32'h0;
    bus.Resolve_taken_IN  = 1'b0;
    bus.Resolve_pred_IN   = 1'b0;
    bus.Update_ready_IN   = 1'b0;
    sbus.Resolve_valid_IN = 1'b0;
    sbus.Resolve_addr_IN  = 32'h0;
    sbus.Resolve_taken_IN = 1'b0;
    sbus.Resolve_pred_IN  = 1'b0;
    sbus.Update_ready_IN  = 1'b0;

    // ---------------- reset state ----------------
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_ready", bus.Resolve_ready_OUT, 1);
    check("rst_valid", bus.Update_valid_OUT, 0);
    check("rst_addr",  bus.Update_addr_OUT, 0);
    check("rst_taken", bus.Update_taken_OUT, 0);
    check("rst_mis",   bus.Mispredict_OUT, 0);
    check("rst_count", bus.Count_OUT, 0);
    check("rst_bcnt",  bus.Branch_count_OUT, 0);
    check("rst_mcnt",  bus.Mispredict_count_OUT, 0);

    // ---------------- single enqueue / dequeue ----------------
    enq(32'h0040_0010, 1'b1, 1'b1);
    check("one_valid", bus.Update_valid_OUT, 1);
    check("one_addr",  bus.Update_addr_OUT, 32'h0040_0010);
    check("one_taken", bus.Update_taken_OUT, 1);
    check("one_mis",   bus.Mispredict_OUT, 0);
    check("one_bcnt",  bus.Branch_count_OUT, 1);
    check("one_count", bus.Count_OUT, 1);
    bus.Update_ready_IN = 1'b1;
    tick();
    bus.Update_ready_IN = 1'b0;
    check("one_empty_valid", bus.Update_valid_OUT, 0);
    check("one_empty_addr",  bus.Update_addr_OUT, 0);
    check("one_empty_count", bus.Count_OUT, 0);

    // ---------------- fill to full, 5th rejected ----------------
    for (int i = 0; i < 5; i++) begin
      check("fill_ready_before", bus.Resolve_ready_OUT, (i < 4) ? 1 : 0);
      enq(32'h0000_1000 + 32'(i * 4), i[0], i[0]);
      check("fill_count", bus.Count_OUT, (i < 4) ? (i + 1) : 4);
    end
    check("full_ready", bus.Resolve_ready_OUT, 0);
    check("full_bcnt",  bus.Branch_count_OUT, 5);
    check("full_mis",   bus.Mispredict_OUT, 0);

    bus.Update_ready_IN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_addr",  bus.Update_addr_OUT, 32'h0000_1000 + 32'(i * 4));
      check("drain_taken", bus.Update_taken_OUT, i[0]);
      tick();
    end
    bus.Update_ready_IN = 1'b0;
    check("drain_empty", bus.Update_valid_OUT, 0);
    check("drain_count", bus.Count_OUT, 0);

    // ---------------- steady enqueue+dequeue at occupancy 2 ----------------
    enq(32'h0000_2000, 1'b0, 1'b0);
    enq(32'h0000_2004, 1'b1, 1'b1);
    check("stream_pre_count", bus.Count_OUT, 2);
    bus.Update_ready_IN = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check("stream_head", bus.Update_addr_OUT, 32'h0000_2000 + 32'(k * 4));
      bus.Resolve_valid_IN = 1'b1;
      bus.Resolve_addr_IN  = 32'h0000_2000 + 32'((k + 2) * 4);
      bus.Resolve_taken_IN = k[0];
      bus.Resolve_pred_IN  = k[0];
      tick();
      check("stream_count", bus.Count_OUT, 2);
    end
    bus.Resolve_valid_IN = 1'b0;
    check("stream_tail0", bus.Update_addr_OUT, 32'h0000_2028);
    tick();
    check("stream_tail1", bus.Update_addr_OUT, 32'h0000_202C);
    tick();
    bus.Update_ready_IN = 1'b0;
    check("stream_empty", bus.Count_OUT, 0);
    check("stream_bcnt",  bus.Branch_count_OUT, 17);

    // ---------------- mispredict pulse and addr-0 discard ----------------
    enq(32'h0000_3000, 1'b0, 1'b1);
    check("mis_pulse", bus.Mispredict_OUT, 1);
    check("mis_mcnt",  bus.Mispredict_count_OUT, 1);
    check("mis_bcnt",  bus.Branch_count_OUT, 18);
    tick();
    check("mis_pulse_end", bus.Mispredict_OUT, 0);
    enq(32'h0000_0000, 1'b1, 1'b0);
    check("zero_mis",   bus.Mispredict_OUT, 0);
    check("zero_mcnt",  bus.Mispredict_count_OUT, 1);
    check("zero_bcnt",  bus.Branch_count_OUT, 18);
    check("zero_count", bus.Count_OUT, 1);
    check("zero_head",  bus.Update_addr_OUT, 32'h0000_3000);
    bus.Update_ready_IN = 1'b1;
    tick();
    bus.Update_ready_IN = 1'b0;
    check("zero_drained", bus.Count_OUT, 0);

    // ---------------- asynchronous reset mid-burst ----------------
    enq(32'h0000_4000, 1'b1, 1'b1);
    enq(32'h0000_4004, 1'b0, 1'b0);
    enq(32'h0000_4008, 1'b1, 1'b0);
    check("burst_count", bus.Count_OUT, 3);
    check("burst_mis",   bus.Mispredict_OUT, 1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_ready", bus.Resolve_ready_OUT, 1);
    check("arst_valid", bus.Update_valid_OUT, 0);
    check("arst_addr",  bus.Update_addr_OUT, 0);
    check("arst_taken", bus.Update_taken_OUT, 0);
    check("arst_mis",   bus.Mispredict_OUT, 0);
    check("arst_count", bus.Count_OUT, 0);
    check("arst_bcnt",  bus.Branch_count_OUT, 0);
    check("arst_mcnt",  bus.Mispredict_count_OUT, 0);
    tick();
    rst = 1'b0;
    enq(32'h0000_5000, 1'b1, 1'b1);
    check("post_rst_count", bus.Count_OUT, 1);
    check("post_rst_head",  bus.Update_addr_OUT, 32'h0000_5000);
    check("post_rst_taken", bus.Update_taken_OUT, 1);
    check("post_rst_bcnt",  bus.Branch_count_OUT, 1);

    // ---------------- counter saturation (CNT_W=3) ----------------
    sbus.Update_ready_IN  = 1'b1;
    sbus.Resolve_valid_IN = 1'b1;
    sbus.Resolve_taken_IN = 1'b1;
    sbus.Resolve_pred_IN  = 1'b0;
    for (int i = 0; i < 9; i++) begin
      sbus.Resolve_addr_IN = 32'h0000_6000 + 32'(i * 4);
      tick();
      check("sat_bcnt", sbus.Branch_count_OUT, (i < 7) ? (i + 1) : 7);
      check("sat_mcnt", sbus.Mispredict_count_OUT, (i < 7) ? (i + 1) : 7);
    end
    sbus.Resolve_valid_IN = 1'b0;
    tick();
    check("sat_hold_bcnt", sbus.Branch_count_OUT, 7);
    check("sat_hold_mcnt", sbus.Mispredict_count_OUT, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
